det_host_ctrl: RTL and testbench

Host-side controller for the determinant engine: the initiator end of the engine's Start/Ack/Done handshake. It accepts an 8x8 signed-integer matrix as a row-major element stream and presents it to the engine as a flat bus. It pulses the engine through I→LOAD→COMP→DONE, captures the 32-bit determinant, acknowledges the engine, and returns the result to the host with a valid/ready handshake and a timeout guard.

---
 rtl/det_pkg.sv | 16 +
 rtl/det_matrix_buf.sv | 29 ++
 rtl/det_host_ctrl.sv | 111 +++++++++++
 tb/tb_det_host_ctrl.sv | 272 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/det_pkg.sv
// Shared constants and the one-hot controller state encoding used by the
// determinant host controller and the engine's state reporting.
package det_pkg;

  localparam int N = 8;
  localparam int W = 32;

  typedef enum logic [4:0] {
    S_FILL  = 5'b00001,
    S_START = 5'b00010,
    S_WAIT  = 5'b00100,
    S_ACK   = 5'b01000,
    S_RES   = 5'b10000
  } state_t;

endpackage

// File: rtl/det_matrix_buf.sv
// N*N x W matrix register file, written one element at a time and presented
// to the engine as a flat bus with element i at bits [i*W +: W].
module det_matrix_buf
  import det_pkg::*;
#(
  parameter int N = det_pkg::N,
  parameter int W = det_pkg::W
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    we,
  input  logic [$clog2(N*N)-1:0]  idx,
  input  logic signed [W-1:0]     data,
  output logic [N*N*W-1:0]        mat_flat
);

  logic [N*N-1:0][W-1:0] mem;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      mem <= '0;
    end else if (we) begin
      mem[idx] <= data;
    end
  end

  assign mat_flat = mem;

endmodule

// File: rtl/det_host_ctrl.sv
// Host-side initiator for the determinant engine: streams a matrix in,
// runs the Start/Ack/Done handshake and returns the result with a timeout guard.
module det_host_ctrl
  import det_pkg::*;
#(
  parameter int N       = det_pkg::N,
  parameter int W       = det_pkg::W,
  parameter int TIMEOUT = 65535
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                in_valid,
  input  logic signed [W-1:0] in_data,
  output logic                in_ready,
  input  logic                in_clear,
  output logic [N*N*W-1:0]    mat_flat,
  output logic                eng_start,
  output logic                eng_ack,
  input  logic                eng_q_I,
  input  logic                eng_q_Done,
  input  logic signed [W-1:0] eng_det,
  output logic                res_valid,
  input  logic                res_ready,
  output logic signed [W-1:0] res_det,
  output logic                res_err,
  output logic                q_Fill,
  output logic                q_Start,
  output logic                q_Wait,
  output logic                q_Ack,
  output logic                q_Res
);

  localparam int NE = N * N;
  localparam int CW = $clog2(NE);
  localparam int TW = $clog2(TIMEOUT + 1);

  state_t        state;
  logic [CW-1:0] cnt;
  logic [TW-1:0] tmo;
  logic          wr_en;

  // A clear in the same cycle as an element wins, so the element is dropped.
  assign wr_en = (state == S_FILL) && in_valid && !in_clear;

  det_matrix_buf #(.N(N), .W(W)) u_buf (
    .clk      (clk),
    .rst      (rst),
    .we       (wr_en),
    .idx      (cnt),
    .data     (in_data),
    .mat_flat (mat_flat)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state   <= S_FILL;
      cnt     <= '0;
      tmo     <= '0;
      res_det <= '0;
      res_err <= 1'b0;
    end else begin
      case (state)
        S_FILL: begin
          if (in_clear) begin
            cnt <= '0;
          end else if (in_valid) begin
            if (cnt == CW'(NE - 1)) begin
              cnt   <= '0;
              state <= S_START;
            end else begin
              cnt <= cnt + 1'b1;
            end
          end
        end
        S_START: if (!eng_q_I) state <= S_WAIT;
        S_WAIT: begin
          tmo <= tmo + 1'b1;
          if (eng_q_Done) begin
            res_det <= eng_det;
            res_err <= 1'b0;
            state   <= S_ACK;
          end else if (tmo == TW'(TIMEOUT)) begin
            res_det <= '0;
            res_err <= 1'b1;
            state   <= S_ACK;
          end
        end
        // Held until the engine is back in I, even after a timeout abort.
        S_ACK: if (eng_q_I) state <= S_RES;
        S_RES: begin
          if (res_ready) begin
            tmo   <= '0;
            state <= S_FILL;
          end
        end
        default: state <= S_FILL;
      endcase
    end
  end

  assign q_Fill    = state[0];
  assign q_Start   = state[1];
  assign q_Wait    = state[2];
  assign q_Ack     = state[3];
  assign q_Res     = state[4];
  assign in_ready  = state[0];
  assign eng_start = state[1];
  assign eng_ack   = state[3];
  assign res_valid = state[4];

endmodule

// File: tb/tb_det_host_ctrl.sv
// Bench for det_host_ctrl: behavioural engine models drive two instances
// (normal and short-timeout); results are matched against a scoreboard queue.
module tb_det_host_ctrl;

  localparam int N  = 8;
  localparam int W  = 32;
  localparam int NE = N * N;
  localparam int TT = 16;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst, rst_t, sel_t;
  logic in_valid, in_clear, res_ready, t_release;
  logic signed [W-1:0] in_data;

  logic in_ready, eng_start, eng_ack, res_valid, res_err;
  logic q_Fill, q_Start, q_Wait, q_Ack, q_Res;
  logic eng_q_I, eng_q_Done;
  logic signed [W-1:0] eng_det, res_det;
  logic [NE*W-1:0] mat_flat;

  logic t_in_ready, t_eng_start, t_eng_ack, t_res_valid, t_res_err;
  logic t_q_Fill, t_q_Start, t_q_Wait, t_q_Ack, t_q_Res;
  logic t_busy;
  logic signed [W-1:0] t_res_det;
  logic [NE*W-1:0] t_mat_flat;

  logic [4:0] qv, tqv;
  assign qv  = {q_Res, q_Ack, q_Wait, q_Start, q_Fill};
  assign tqv = {t_q_Res, t_q_Ack, t_q_Wait, t_q_Start, t_q_Fill};

  det_host_ctrl #(.N(N), .W(W)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid & ~sel_t), .in_data(in_data),
    .in_ready(in_ready), .in_clear(in_clear & ~sel_t), .mat_flat(mat_flat),
    .eng_start(eng_start), .eng_ack(eng_ack), .eng_q_I(eng_q_I),
    .eng_q_Done(eng_q_Done), .eng_det(eng_det), .res_valid(res_valid),
    .res_ready(res_ready), .res_det(res_det), .res_err(res_err),
    .q_Fill(q_Fill), .q_Start(q_Start), .q_Wait(q_Wait), .q_Ack(q_Ack), .q_Res(q_Res)
  );

  det_host_ctrl #(.N(N), .W(W), .TIMEOUT(TT)) dut_t (
    .clk(clk), .rst(rst_t), .in_valid(in_valid & sel_t), .in_data(in_data),
    .in_ready(t_in_ready), .in_clear(in_clear & sel_t), .mat_flat(t_mat_flat),
    .eng_start(t_eng_start), .eng_ack(t_eng_ack), .eng_q_I(~t_busy),
    .eng_q_Done(1'b0), .eng_det(32'sh12345678), .res_valid(t_res_valid),
    .res_ready(res_ready), .res_det(t_res_det), .res_err(t_res_err),
    .q_Fill(t_q_Fill), .q_Start(t_q_Start), .q_Wait(t_q_Wait), .q_Ack(t_q_Ack), .q_Res(t_q_Res)
  );

  // Engine model: I -> LOAD -> COMP (e_lat cycles) -> DONE until Ack.
  logic [1:0] e_st;
  int e_cnt;
  int e_lat;
  logic signed [W-1:0] e_det;
  always @(posedge clk or posedge rst) begin
    if (rst) begin
      e_st  <= 2'd0;
      e_cnt <= 0;
    end else begin
      case (e_st)
        2'd0: if (eng_start) e_st <= 2'd1;
        2'd1: begin e_st <= 2'd2; e_cnt <= 0; end
        2'd2: if (e_cnt >= e_lat - 1) e_st <= 2'd3; else e_cnt <= e_cnt + 1;
        default: if (eng_ack) e_st <= 2'd0;
      endcase
    end
  end
  assign eng_q_I    = (e_st == 2'd0);
  assign eng_q_Done = (e_st == 2'd3);
  assign eng_det    = (e_st == 2'd3) ? e_det : 32'shDEADBEEF;

  // Stuck engine for the timeout instance: leaves I on Start, returns only on release.
  always @(posedge clk or posedge rst_t) begin
    if (rst_t) t_busy <= 1'b0;
    else if (!t_busy && t_eng_start) t_busy <= 1'b1;
    else if (t_busy && t_release) t_busy <= 1'b0;
  end

  int n_chk = 0;
  int n_pass = 0;
  logic [32:0] sb[$];

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  always @(negedge clk) begin
    if (res_valid && res_ready) begin
      if (sb.size() == 0) begin
        check("sb_unexpected_result", 32'd1, 32'd0);
      end else begin
        logic [32:0] e;
        e = sb.pop_front();
        check("res_det", res_det, e[31:0]);
        check("res_err", {31'b0, res_err}, {31'b0, e[32]});
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_q(input bit t, input int bitn, input int lim, input string tag);
    logic [4:0] v;
    for (int i = 0; i < lim; i++) begin
      v = t ? tqv : qv;
      if (v[bitn]) return;
      tick();
    end
    check({tag, "_timeout"}, 32'd0, 32'd1);
  endtask

  function automatic int elem(input int kind, input int i);
    case (kind)
      0: return (i / N == i % N) ? 1 : 0;
      1: return 100 * (i / N) + (i % N);
      default: return i * 37 - 1000;
    endcase
  endfunction

  task automatic load(input bit t, input int kind, input bit gaps, input int first, input int n);
    sel_t = t;
    wait_q(t, 0, 300, "load_fill");
    for (int i = first; i < first + n; i++) begin
      if (gaps && $urandom_range(0, 2) == 0) begin
        in_valid = 1'b0;
        repeat ($urandom_range(1, 2)) tick();
      end
      in_valid = 1'b1;
      in_data  = elem(kind, i);
      tick();
    end
    in_valid = 1'b0;
  endtask

  task automatic chk_reset(input string tag);
    check({tag, "_q"}, {27'b0, qv}, 32'd1);
    check({tag, "_in_ready"}, {31'b0, in_ready}, 32'd1);
    check({tag, "_start_ack"}, {30'b0, eng_start, eng_ack}, 32'd0);
    check({tag, "_res_valid"}, {31'b0, res_valid}, 32'd0);
    check({tag, "_res"}, res_det | {31'b0, res_err}, 32'd0);
    check({tag, "_mat"}, {31'b0, |mat_flat}, 32'd0);
  endtask

  initial begin
    int sc, ac, wc;
    rst = 1'b1; rst_t = 1'b1; sel_t = 1'b0; t_release = 1'b0;
    in_valid = 1'b0; in_clear = 1'b0; in_data = '0; res_ready = 1'b1;
    e_lat = 20; e_det = 32'sd1;
    tick(); tick();
    chk_reset("rst0");
    rst = 1'b0;
    tick();

    // Identity, engine returns 1 after 20 cycles
    sb.push_back({1'b0, 32'd1});
    load(0, 0, 0, 0, NE);
    check("t1_start", {31'b0, eng_start}, 32'd1);
    sc = 0;
    while (eng_start && sc < 10) begin sc++; tick(); end
    check("t1_start_cycles", sc, 32'd2);
    check("t1_qI_low", {31'b0, eng_q_I}, 32'd0);
    for (int i = 0; i < 100 && !eng_ack; i++) tick();
    check("t1_ack_seen", {31'b0, eng_ack}, 32'd1);
    ac = 0;
    while (eng_ack && ac < 10) begin ac++; tick(); end
    check("t1_ack_cycles", ac, 32'd2);
    check("t1_qI_high", {31'b0, eng_q_I}, 32'd1);
    check("t1_res_valid", {31'b0, res_valid}, 32'd1);
    tick();

    // 100r+c with gaps and a clear at cnt=17, then full reload
    e_det = 32'sd7;
    sb.push_back({1'b0, 32'd7});
    load(0, 0, 1, 0, 17);
    in_clear = 1'b1; in_valid = 1'b1; in_data = 32'sd999;
    tick();
    in_clear = 1'b0; in_valid = 1'b0;
    load(0, 1, 1, 0, NE);
    check("t2_start", {27'b0, qv}, 32'd2);
    for (int i = 0; i < NE; i++)
      check($sformatf("t2_mat%0d", i), mat_flat[i*W +: W], elem(1, i));
    wait_q(0, 0, 200, "t2_done");

    // det=-720 with res_ready held low 5 cycles
    res_ready = 1'b0;
    e_det = -32'sd720;
    sb.push_back({1'b0, 32'hFFFFFD30});
    load(0, 2, 0, 0, NE);
    wait_q(0, 4, 200, "t3_res");
    for (int k = 0; k < 5; k++) begin
      check("t3_hold_valid", {31'b0, res_valid}, 32'd1);
      check("t3_hold_det", res_det, 32'hFFFFFD30);
      tick();
    end
    res_ready = 1'b1;
    tick();
    check("t3_fill", {27'b0, qv}, 32'd1);
    check("t3_det_kept", res_det, 32'hFFFFFD30);

    // Timeout with engine stuck in COMP
    res_ready = 1'b0;
    rst_t = 1'b0;
    tick();
    load(1, 2, 0, 0, NE);
    wait_q(1, 2, 20, "t4_wait");
    wc = 0;
    while (t_q_Wait && wc < 100) begin wc++; tick(); end
    check("t4_wait_cycles", wc, TT + 1);
    check("t4_ack", {31'b0, t_eng_ack}, 32'd1);
    check("t4_err", {31'b0, t_res_err}, 32'd1);
    check("t4_det", t_res_det, 32'd0);
    repeat (5) tick();
    check("t4_ack_held", {27'b0, tqv}, 32'h8);
    t_release = 1'b1;
    wait_q(1, 4, 5, "t4_res");
    t_release = 1'b0;
    check("t4_res_valid", {31'b0, t_res_valid}, 32'd1);
    check("t4_res_err", {31'b0, t_res_err}, 32'd1);
    res_ready = 1'b1;
    tick();
    check("t4_fill", {27'b0, tqv}, 32'd1);
    sel_t = 1'b0;

    // Reset mid-WAIT and mid-ACK, then a normal load
    e_det = 32'sd5;
    load(0, 2, 0, 0, NE);
    wait_q(0, 2, 20, "t5_wait");
    repeat (3) tick();
    #2 rst = 1'b1;
    #1 chk_reset("t5_rst_wait");
    #3 rst = 1'b0;
    tick();
    load(0, 1, 0, 0, NE);
    wait_q(0, 3, 200, "t5_ack");
    check("t5_det_captured", res_det, 32'd5);
    #2 rst = 1'b1;
    #1 chk_reset("t5_rst_ack");
    #3 rst = 1'b0;
    tick();
    e_det = 32'sd9;
    sb.push_back({1'b0, 32'd9});
    load(0, 0, 0, 0, NE);
    wait_q(0, 4, 200, "t5_res");
    tick();

    // Back-to-back with res_ready high
    e_det = 32'sd2;
    sb.push_back({1'b0, 32'd2});
    load(0, 0, 0, 0, NE);
    wait_q(0, 4, 200, "t6_res1");
    tick();
    check("t6_ready1", {31'b0, in_ready}, 32'd1);
    check("t6_valid1_low", {31'b0, res_valid}, 32'd0);
    e_det = 32'sd6;
    sb.push_back({1'b0, 32'd6});
    load(0, 1, 0, 0, NE);
    wait_q(0, 4, 200, "t6_res2");
    tick();
    check("t6_ready2", {31'b0, in_ready}, 32'd1);
    check("sb_drained", sb.size(), 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
